// File: rtl/trig_seq.sv
// trig_seq: multi-stage sequential trigger; each stage has a mask/pattern match and an occurrence count.
// Latency: a completing sample is registered at edge k and trig pulses for the cycle after edge k+1 (+ delay).
// No backpressure: data is sampled every cycle; config writes outside IDLE or out of range are dropped and flagged on cfg_err.
module trig_seq #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int AW    = $clog2(STAGES) + 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             arm,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             trig,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DELAY = 2'd2,
    FIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             trig_q, trig_d;
  logic [WIDTH-1:0] data_q;

  // Per-stage configuration; stage 0 also owns the post-trigger delay.
  logic [WIDTH-1:0] mask_r    [STAGES];
  logic [WIDTH-1:0] pattern_r [STAGES];
  logic [CNT_W-1:0] count_r   [STAGES];
  logic [CNT_W-1:0] delay_r;

  // Config address decode: {stage index, field}.
  logic [SW-1:0]    cfg_idx;
  logic [1:0]       cfg_field;
  logic [CNT_W-1:0] cfg_cnt;
  logic             idx_ok;
  logic             cfg_ok;

  assign cfg_field = cfg_addr[1:0];
  assign cfg_cnt   = CNT_W'(cfg_data);

  generate
    if (STAGES > 1) begin : g_idx
      assign cfg_idx = cfg_addr[AW-1:2];
    end else begin : g_idx_one
      assign cfg_idx = '0;
    end
  endgenerate

  assign idx_ok = (32'(cfg_idx) < STAGES);
  assign cfg_ok = (state_q == IDLE) && idx_ok;

  // Configuration storage; writes land only while idle and in range, rejects pulse cfg_err next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        mask_r[i]    <= '0;
        pattern_r[i] <= '0;
        count_r[i]   <= CNT_W'(1);
      end
      delay_r <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        case (cfg_field)
          2'd0:    mask_r[cfg_idx]    <= cfg_data;
          2'd1:    pattern_r[cfg_idx] <= cfg_data;
          2'd2:    count_r[cfg_idx]   <= cfg_cnt;
          default: if (cfg_idx == '0) delay_r <= cfg_cnt;
        endcase
      end
    end
  end

  // Current-stage compare against the registered sample; mask bit 0 means don't-care.
  logic [WIDTH-1:0] cur_mask;
  logic [WIDTH-1:0] cur_pat;
  logic [CNT_W-1:0] cnt_eff;
  logic             stage_match;
  logic             occ_done;
  logic             dcnt_done;
  logic             last_stage;

  assign cur_mask    = mask_r[stage_q];
  assign cur_pat     = pattern_r[stage_q];
  assign cnt_eff     = (count_r[stage_q] == '0) ? CNT_W'(1) : count_r[stage_q];
  assign stage_match = ((data_q & cur_mask) == (cur_pat & cur_mask));
  assign occ_done    = ((CNT_W+1)'(occ_q) + 1'b1) >= (CNT_W+1)'(cnt_eff);
  assign dcnt_done   = ((CNT_W+1)'(dcnt_q) + 1'b1) >= (CNT_W+1)'(delay_r);
  assign last_stage  = (stage_q == SW'(STAGES - 1));

  // Probe sampling, independent of the sequencer state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data;
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      occ_q   <= '0;
      dcnt_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      occ_q   <= occ_d;
      dcnt_q  <= dcnt_d;
      trig_q  <= trig_d;
    end
  end

  // Next-state logic; dropping arm always wins and never fires.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    occ_d   = occ_q;
    dcnt_d  = dcnt_q;
    trig_d  = 1'b0;
    if (!arm) begin
      state_d = IDLE;
      stage_d = '0;
      occ_d   = '0;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stage_d = '0;
          occ_d   = '0;
          dcnt_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          if (stage_match) begin
            if (occ_done) begin
              occ_d = '0;
              if (last_stage) begin
                if (delay_r == '0) begin
                  state_d = FIRED;
                  trig_d  = 1'b1;
                end else begin
                  state_d = DELAY;
                  dcnt_d  = '0;
                end
              end else begin
                stage_d = stage_q + 1'b1;
              end
            end else if (occ_q != '1) begin
              occ_d = occ_q + 1'b1;
            end
          end
        end
        DELAY: begin
          if (dcnt_done) begin
            state_d = FIRED;
            trig_d  = 1'b1;
          end else if (dcnt_q != '1) begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = FIRED;
        end
      endcase
    end
  end

  assign trig  = trig_q;
  assign done  = (state_q == FIRED);
  assign stage = stage_q;

endmodule

// File: tb/tb_trig_seq.sv
// tb_trig_seq: directed stimulus for trig_seq with a scoreboard of expected trig/cfg_err pulses.
// Expected pulse cycles are hand-computed relative to the arm cycle and queued ahead of time.
// A negedge monitor pops and compares each pulse; level outputs are checked inline.
module tb_trig_seq;
  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
  localparam int SW     = 2;
  localparam int AW     = 4;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic [WIDTH-1:0] data     = '0;
  logic             arm      = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic             trig;
  logic             done;
  logic [SW-1:0]    stage;
  logic             cfg_err;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int a;

  typedef struct {
    int kind;   // 0 = trig, 1 = cfg_err
    int at;     // cycle count at the sampling negedge
  } ev_t;
  ev_t exp_q[$];

  trig_seq #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .data     (data),
    .arm      (arm),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .trig     (trig),
    .done     (done),
    .stage    (stage),
    .cfg_err  (cfg_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event_%s: unexpected pulse at cycle %0d, none queued", kind == 0 ? "trig" : "cfg_err", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        failures++;
        $display("FAIL event_%s: got pulse at cycle %0d, expected kind %0d at cycle %0d",
                 kind == 0 ? "trig" : "cfg_err", cyc, e.kind, e.at);
      end
    end
  endtask

  // Scoreboard monitor: every output pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (trig)    check_event(0);
      if (cfg_err) check_event(1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cfg_write(input int idx, input int field, input int val, input bit expect_err);
    cfg_we   = 1'b1;
    cfg_addr = AW'((idx << 2) | field);
    cfg_data = WIDTH'(val);
    if (expect_err) expect_ev(1, cyc + 1);
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    arm    = 1'b0;
    cfg_we = 1'b0;
    data   = '0;
    tick(2);
    reset  = 1'b0;
  endtask

  initial begin
    // Reset state while reset is held.
    tick(2);
    chk("rst_trig", trig, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage, 0);
    chk("rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    tick(1);

    // Default config matches anything: one cycle per stage after entering RUN.
    arm = 1'b1; a = cyc; expect_ev(0, a + 4);
    tick(2); chk("t1_stage_a2", stage, 1);
    tick(1); chk("t1_stage_a3", stage, 2);
    chk("t1_done_before", done, 0);
    tick(2); chk("t1_done_after", done, 1);
    arm = 1'b0;
    tick(1); chk("t1_done_disarm", done, 0);
    chk("t1_stage_disarm", stage, 0);

    // Occurrence count 3 on stage 0, non-consecutive matches still count.
    do_reset();
    cfg_write(0, 0, 'hFF, 0);
    cfg_write(0, 1, 'h12, 0);
    cfg_write(0, 2, 3, 0);
    data = '0; arm = 1'b1; a = cyc; expect_ev(0, a + 8);
    tick(1); data = 'h12;
    tick(1); data = 'h00;
    tick(1); data = 'h12;
    tick(1); data = 'h12;
    tick(1); data = 'h00; chk("t2_stage_a5", stage, 0);
    tick(1); chk("t2_stage_a6", stage, 1);
    tick(3); chk("t2_done", done, 1);
    arm = 1'b0; tick(1);

    // Ordered stages A, B, C (low nibble); count 0 on stage 2 acts as 1.
    do_reset();
    cfg_write(0, 0, 'h0F, 0); cfg_write(0, 1, 'h0A, 0);
    cfg_write(1, 0, 'h0F, 0); cfg_write(1, 1, 'h0B, 0);
    cfg_write(2, 0, 'h0F, 0); cfg_write(2, 1, 'h0C, 0);
    cfg_write(2, 2, 0, 0);
    data = '0; arm = 1'b1; a = cyc; expect_ev(0, a + 7);
    tick(1); data = 'h0B;
    tick(1); data = 'h0A;
    tick(1); data = 'h0A; chk("t3_stage_a3", stage, 0);
    tick(1); data = 'h0B; chk("t3_stage_a4", stage, 1);
    tick(1); data = 'hFC; chk("t3_stage_a5", stage, 1);
    tick(1); data = 'h00; chk("t3_stage_a6", stage, 2);
    tick(2); chk("t3_done", done, 1);
    arm = 1'b0; tick(1);

    // Post-trigger delay 5; field 3 of stage 1 is ignored without error.
    do_reset();
    cfg_write(0, 3, 5, 0);
    cfg_write(1, 3, 7, 0);
    arm = 1'b1; a = cyc; expect_ev(0, a + 9);
    tick(8); chk("t4_done_in_delay", done, 0);
    tick(2); chk("t4_done_after", done, 1);
    arm = 1'b0;
    tick(1); chk("t4_done_disarm", done, 0);
    // Abort in the middle of the delay: no trig, done stays low.
    arm = 1'b1; a = cyc;
    tick(6);
    arm = 1'b0;
    tick(1); chk("t4_abort_done", done, 0);
    chk("t4_abort_stage", stage, 0);
    tick(6); chk("t4_abort_done_late", done, 0);

    // Rejected writes: out-of-range stage index, and any write while running.
    do_reset();
    cfg_write(0, 0, 'hFF, 0);
    cfg_write(0, 1, 'h33, 0);
    cfg_write(3, 1, 'h00, 1);
    data = '0; arm = 1'b1; a = cyc;
    tick(2);
    cfg_write(0, 1, 'h00, 1);
    tick(3); chk("t5_stage_held", stage, 0);
    data = 'h33; expect_ev(0, a + 10);
    tick(1); data = 'h00;
    tick(4); chk("t5_done", done, 1);
    arm = 1'b0; tick(1);

    // Reset while stalled at stage 1 clears outputs and restores defaults.
    do_reset();
    cfg_write(1, 0, 'hFF, 0);
    cfg_write(1, 1, 'h77, 0);
    cfg_write(0, 3, 3, 0);
    data = '0; arm = 1'b1; a = cyc;
    tick(4); chk("t6_stage_stall", stage, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_stage", stage, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_trig", trig, 0);
    chk("t6_rst_cfg_err", cfg_err, 0);
    arm = 1'b0;
    tick(2);
    reset = 1'b0;
    arm = 1'b1; a = cyc; expect_ev(0, a + 4);
    tick(5); chk("t6_done_defaults", done, 1);
    arm = 1'b0; tick(1);

    tick(10);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events: %0d pulses never seen, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
